// File: rtl/updown_counter_bank.sv
// Bank of independent up/down counters with synchronous load, wrap or saturate
// boundary handling, a one-cycle terminal-count pulse and a sticky overflow flag.
module updown_counter_bank #(
    parameter int WIDTH    = 5,
    parameter int CHANNELS = 2,
    parameter int SATURATE = 0
) (
    input  logic                      clk0,
    input  logic                      reset,
    input  logic [CHANNELS-1:0]       en,
    input  logic [CHANNELS-1:0]       dir,
    input  logic [CHANNELS-1:0]       load,
    input  logic [CHANNELS*WIDTH-1:0] load_val,
    input  logic [CHANNELS-1:0]       clr_ovf,
    output logic [CHANNELS*WIDTH-1:0] count,
    output logic [CHANNELS-1:0]       tc,
    output logic [CHANNELS-1:0]       ovf
);

    localparam logic             SAT_MODE = (SATURATE != 0);
    localparam logic [WIDTH-1:0] MAX_VAL  = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] MIN_VAL  = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [CHANNELS-1:0][WIDTH-1:0] count_q, count_d;
    logic [CHANNELS-1:0]            tc_q, tc_d;
    logic [CHANNELS-1:0]            ovf_q, ovf_d;

    // Next-state for every channel: load beats enable; a step at the boundary flags tc/ovf.
    always_comb begin
        count_d = count_q;
        tc_d    = {CHANNELS{1'b0}};
        ovf_d   = ovf_q & ~clr_ovf;
        for (int i = 0; i < CHANNELS; i++) begin
            if (load[i]) begin
                count_d[i] = load_val[i*WIDTH +: WIDTH];
            end else if (en[i]) begin
                if (dir[i]) begin
                    if (count_q[i] == MAX_VAL) begin
                        count_d[i] = SAT_MODE ? MAX_VAL : MIN_VAL;
                        tc_d[i]    = 1'b1;
                        ovf_d[i]   = 1'b1;
                    end else begin
                        count_d[i] = count_q[i] + ONE;
                    end
                end else begin
                    if (count_q[i] == MIN_VAL) begin
                        count_d[i] = SAT_MODE ? MIN_VAL : MAX_VAL;
                        tc_d[i]    = 1'b1;
                        ovf_d[i]   = 1'b1;
                    end else begin
                        count_d[i] = count_q[i] - ONE;
                    end
                end
            end else begin
                count_d[i] = count_q[i];
            end
        end
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk0) begin
        if (reset) begin
            count_q <= '0;
            tc_q    <= {CHANNELS{1'b0}};
            ovf_q   <= {CHANNELS{1'b0}};
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
            ovf_q   <= ovf_d;
        end
    end

    assign count = count_q;
    assign tc    = tc_q;
    assign ovf   = ovf_q;

endmodule
